load_store_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 8 +
 rtl/load_store_unit_lane_merge.sv | 24 ++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package mips_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, RMW} lsu_state_t;
endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Replaces one byte or half lane of a memory word with new store data.
module lane_merge
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_old,
    input  logic [15:0]      i_new,
    input  logic [1:0]       i_lane,
    input  logic [1:0]       i_size,
    output logic [WIDTH-1:0] o_merged
);

    // Half stores use lane[1] only; the alignment check has already rejected lane[0]=1.
    always_comb begin
        o_merged = i_old;
        case (i_size)
            SZ_BYTE: o_merged[i_lane*8 +: 8]     = i_new[7:0];
            SZ_HALF: o_merged[i_lane[1]*16 +: 16] = i_new;
            default: o_merged = i_old;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: word indexing, load extension,
// direct word stores and two-cycle read-modify-write sub-word stores.
module load_store_unit
    import mips_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MEM_WORDS = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       size,
    input  logic             load_unsigned,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] dm_address,
    output logic [WIDTH-1:0] dm_wdata,
    output logic             dm_wen,
    input  logic [WIDTH-1:0] dm_rdata,
    output logic [WIDTH-1:0] load_data,
    output logic             load_valid,
    output logic             stall,
    output logic             access_fault
);

    lsu_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_old, r_addr;
    logic [15:0]      r_data;
    logic [1:0]       r_size;

    logic             w_misalign, w_range_bad, w_fault, w_sub_store, w_word_store, w_load;
    logic [WIDTH-1:0] w_word_idx, w_merged, w_ext;
    logic [1:0]       w_lane;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    assign w_lane      = addr[1:0];
    assign w_word_idx  = {2'b00, addr[WIDTH-1:2]};
    assign w_range_bad = (w_word_idx >= WIDTH'(MEM_WORDS));

    // Alignment rules by access size; the reserved size always faults.
    always_comb begin
        w_misalign = 1'b0;
        case (size)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = addr[0];
            SZ_WORD: w_misalign = (addr[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    // A simultaneous read and write request is malformed and treated as a fault.
    assign w_fault      = (mem_read | mem_write) &
                          ((mem_read & mem_write) | w_misalign | w_range_bad);
    assign w_load       = mem_read & ~w_fault;
    assign w_word_store = mem_write & ~w_fault & (size == SZ_WORD);
    assign w_sub_store  = mem_write & ~w_fault & ((size == SZ_BYTE) | (size == SZ_HALF));

    // Load lane extraction and sign/zero extension.
    assign w_byte = dm_rdata[w_lane*8 +: 8];
    assign w_half = dm_rdata[w_lane[1]*16 +: 16];
    always_comb begin
        w_ext = dm_rdata;
        case (size)
            SZ_BYTE: w_ext = {{(WIDTH-8){~load_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_ext = {{(WIDTH-16){~load_unsigned & w_half[15]}}, w_half};
            default: w_ext = dm_rdata;
        endcase
    end

    lane_merge #(.WIDTH(WIDTH)) u_merge (
        .i_old    (r_old),
        .i_new    (r_data),
        .i_lane   (r_addr[1:0]),
        .i_size   (r_size),
        .o_merged (w_merged)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and memory-side outputs; stall and write enable are gated
    // by reset so nothing leaks out while the unit is held in reset.
    always_comb begin
        w_next     = r_state;
        stall      = 1'b0;
        dm_wen     = 1'b0;
        dm_wdata   = store_data;
        dm_address = w_word_idx;
        case (r_state)
            IDLE: begin
                if (w_sub_store) begin
                    stall  = rst_n;
                    w_next = RMW;
                end else if (w_word_store) begin
                    dm_wen = rst_n;
                end
            end
            RMW: begin
                dm_address = {2'b00, r_addr[WIDTH-1:2]};
                dm_wdata   = w_merged;
                dm_wen     = rst_n;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered load result, fault pulse and RMW capture; inputs are ignored in RMW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data    <= '0;
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            r_old        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_size       <= '0;
        end else begin
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            if (r_state == IDLE) begin
                access_fault <= w_fault;
                if (w_load) begin
                    load_data  <= w_ext;
                    load_valid <= 1'b1;
                end
                if (w_sub_store) begin
                    r_old  <= dm_rdata;
                    r_addr <= addr;
                    r_data <= store_data[15:0];
                    r_size <= size;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 100-word behavioural data memory.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = '0, store_data = '0;
    logic [31:0] dm_address, dm_wdata, dm_rdata, load_data;
    logic        dm_wen, load_valid, stall, access_fault;

    logic [31:0] mem [0:99];
    int          npass = 0, ntot = 0;
    logic [31:0] held;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .MEM_WORDS(100)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .load_unsigned(load_unsigned), .addr(addr), .store_data(store_data),
        .dm_address(dm_address), .dm_wdata(dm_wdata), .dm_wen(dm_wen), .dm_rdata(dm_rdata),
        .load_data(load_data), .load_valid(load_valid), .stall(stall), .access_fault(access_fault)
    );

    assign dm_rdata = (dm_address < 32'd100) ? mem[dm_address[6:0]] : 32'h0;
    always @(posedge clk) if (dm_wen && dm_address < 32'd100) mem[dm_address[6:0]] <= dm_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        mem_read = rd; mem_write = wr; size = sz; load_unsigned = uns; addr = a; store_data = d;
    endtask

    // One load: present at negedge, check registered result just after the edge.
    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk); drive(1, 0, sz, uns, a, 0);
        #1 chk({tag, "_stall"}, {31'b0, stall}, 0);
        @(posedge clk); #1;
        chk({tag, "_data"}, load_data, exp);
        chk({tag, "_valid"}, {31'b0, load_valid}, 1);
    endtask

    // One faulting access: no write, no stall, one-cycle fault pulse, load_data held.
    task automatic do_fault(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic [31:0] a);
        @(negedge clk); drive(rd, wr, sz, 0, a, 32'h5A5A5A5A);
        #1 chk({tag, "_wen"}, {31'b0, dm_wen}, 0);
        chk({tag, "_stall"}, {31'b0, stall}, 0);
        @(posedge clk); #1;
        chk({tag, "_fault"}, {31'b0, access_fault}, 1);
        chk({tag, "_valid"}, {31'b0, load_valid}, 0);
        chk({tag, "_held"}, load_data, held);
        @(negedge clk); drive(0, 0, 2'b10, 0, 0, 0);
        #1 chk({tag, "_wen2"}, {31'b0, dm_wen}, 0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'b0, access_fault}, 0);
    endtask

    initial begin
        for (int i = 0; i < 100; i++) mem[i] = 32'h0;
        drive(0, 0, 2'b10, 0, 0, 0);

        // Reset state
        #2;
        chk("rst_ld", load_data, 0);
        chk("rst_vld", {31'b0, load_valid}, 0);
        chk("rst_flt", {31'b0, access_fault}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_wen", {31'b0, dm_wen}, 0);
        @(negedge clk); rst_n = 1'b1;

        // SW 0x8 = DEADBEEF
        @(negedge clk); drive(0, 1, 2'b10, 0, 32'h8, 32'hDEADBEEF);
        #1 chk("sw_addr", dm_address, 2);
        chk("sw_wen", {31'b0, dm_wen}, 1);
        chk("sw_wdata", dm_wdata, 32'hDEADBEEF);
        chk("sw_stall", {31'b0, stall}, 0);
        @(posedge clk); #1 chk("sw_vld", {31'b0, load_valid}, 0);

        do_load("lw", 2'b10, 0, 32'h8, 32'hDEADBEEF);
        do_load("lb", 2'b00, 0, 32'hB, 32'hFFFFFFDE);
        do_load("lbu", 2'b00, 1, 32'hB, 32'h000000DE);
        do_load("lh", 2'b01, 0, 32'h8, 32'hFFFFBEEF);
        do_load("lhu", 2'b01, 1, 32'hA, 32'h0000DEAD);

        @(negedge clk); drive(0, 0, 2'b10, 0, 0, 0);
        @(posedge clk); #1 chk("idle_vld", {31'b0, load_valid}, 0);

        // SB 0x9 = 0x12: one stall cycle, then merged write
        @(negedge clk); drive(0, 1, 2'b00, 0, 32'h9, 32'h12);
        #1 chk("sb_stall1", {31'b0, stall}, 1);
        chk("sb_wen1", {31'b0, dm_wen}, 0);
        @(negedge clk);
        #1 chk("sb_stall2", {31'b0, stall}, 0);
        chk("sb_wen2", {31'b0, dm_wen}, 1);
        chk("sb_addr2", dm_address, 2);
        chk("sb_wdata", dm_wdata, 32'hDEAD12EF);
        @(posedge clk); #1 chk("sb_vld", {31'b0, load_valid}, 0);
        do_load("sb_lw", 2'b10, 0, 32'h8, 32'hDEAD12EF);

        // SH 0xA = 0xCAFE
        @(negedge clk); drive(0, 1, 2'b01, 0, 32'hA, 32'hCAFE);
        #1 chk("sh_stall1", {31'b0, stall}, 1);
        @(negedge clk);
        #1 chk("sh_stall2", {31'b0, stall}, 0);
        chk("sh_wen2", {31'b0, dm_wen}, 1);
        chk("sh_wdata", dm_wdata, 32'hCAFE12EF);
        do_load("sh_lw", 2'b10, 0, 32'h8, 32'hCAFE12EF);

        // Faults
        held = 32'hCAFE12EF;
        do_fault("f_lw6", 1, 0, 2'b10, 32'h6);
        do_fault("f_sh5", 0, 1, 2'b01, 32'h5);
        do_fault("f_sw400", 0, 1, 2'b10, 32'd400);
        do_fault("f_rdwr", 1, 1, 2'b10, 32'h8);
        do_fault("f_rsvd", 1, 0, 2'b11, 32'h8);
        chk("f_mem2", mem[2], 32'hCAFE12EF);

        // Reset while in RMW abandons the write
        @(negedge clk); drive(0, 1, 2'b00, 0, 32'h8, 32'h55);
        @(negedge clk);
        #1 chk("rr_wen_rmw", {31'b0, dm_wen}, 1);
        #1 rst_n = 1'b0;
        #1 chk("rr_wen", {31'b0, dm_wen}, 0);
        chk("rr_stall", {31'b0, stall}, 0);
        chk("rr_ld", load_data, 0);
        chk("rr_flt", {31'b0, access_fault}, 0);
        @(posedge clk); #1;
        chk("rr_mem", mem[2], 32'hCAFE12EF);
        @(negedge clk); drive(0, 0, 2'b10, 0, 0, 0); rst_n = 1'b1;
        #1 chk("rr_idle_wen", {31'b0, dm_wen}, 0);
        do_load("rr_lw", 2'b10, 0, 32'h8, 32'hCAFE12EF);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
